serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial unsigned subtractor: computes a - b LSB-first, one bit per clock.
//  Uses a single full_adder cell with b inverted and a registered carry (carry-in = 1),
//  i.e. a + ~b + 1. This is the sequential companion to the combinational full_adder,
//  and the first arithmetic block in the chain to use a start/done handshake.
// PARAMETERS
//  WIDTH   8   operand and result width in bits (>= 2)
// PORTS
//  clk       in   1      single clock; all state updates on posedge
//  rst       in   1      synchronous, active-high reset
//  start     in   1      request; sampled only when ready=1
//  a         in   WIDTH  minuend; captured on the accepted start edge
//  b         in   WIDTH  subtrahend; captured on the accepted start edge
//  ready     out  1      1 = idle, start will be accepted
//  done      out  1      one-cycle pulse; diff/borrow are valid from this cycle
//  diff      out  WIDTH  a - b mod 2^WIDTH
//  borrow    out  1      1 iff a < b (unsigned); equals ~final carry
//  overflow  out  1      only with SERIAL_SUB_OVERFLOW_EN; signed overflow flag
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE, ready=1, done=0, diff=0, borrow=0,
//    overflow=0, count=0, carry=1. Reset wins over every other input in the same cycle.
//  - FSM states:
//      IDLE:  ready=1. On start=1: load shift regs sa<=a, sb<=b; carry<=1; count<=0;
//             go to SHIFT.
//      SHIFT: ready=0. Each edge: s = sa[0]^~sb[0]^carry, carry <= full_adder cout;
//             shift s into the result reg from the MSB; shift sa and sb right; count++.
//             On the edge where count==WIDTH-1: diff<=final result, borrow<=~cout,
//             done<=1, go to DONE.
//      DONE:  ready=0, done=1 for exactly this cycle. Next edge: done<=0, go to IDLE.
//  - Latency: the start is accepted at edge E0; done is high in the cycle after edge
//    E0+WIDTH. Issue interval is WIDTH+2 cycles.
//  - start while in SHIFT or DONE: ignored. The request is not queued and the operands
//    in flight are unchanged.
//  - a and b may change freely after the accepted edge; only the captured values are used.
//  - diff and borrow keep the previous result throughout SHIFT and change only on the
//    completion edge. They hold until the next completion or reset.
//  - Reset mid-SHIFT: the operation is aborted, no done pulse is produced, and outputs
//    return to their reset values.
//  - Arithmetic: the result is modulo 2^WIDTH, with no saturation.
//    a == b gives diff=0, borrow=0.
// CONFIGURATION
//  SERIAL_SUB_OVERFLOW_EN defined:
//    - The overflow port exists.
//    - On the completion edge: overflow <= (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]),
//      evaluated on the captured operands.
//    - overflow holds with diff and resets to 0.
//  SERIAL_SUB_OVERFLOW_EN undefined:
//    - No overflow port and no related logic.
//    - All other behaviour is identical.
// TESTING (WIDTH=8 unless noted; check via `assert)
//  1. Reset, then start with a=5, b=3 -> done high in the cycle after the 8th edge
//     following acceptance; diff=2, borrow=0; ready=1 one cycle later.
//  2. a=3, b=5 -> diff=8'hFE, borrow=1.
//     a=8'hA5, b=8'hA5 -> diff=0, borrow=0.
//     a=0, b=1 -> diff=8'hFF, borrow=1.
//  3. Overflow build: a=8'h80, b=1 -> diff=8'h7F, borrow=0, overflow=1.
//     a=8'h7F, b=8'hFF -> diff=8'h80, borrow=1, overflow=1.
//     a=10, b=4 -> overflow=0.
//  4. Pulse start during SHIFT with a=b=0 -> ignored; the first result stands and
//     exactly one done pulse occurs.
//     Hold start=1 continuously -> one operation every WIDTH+2 cycles.
//  5. Assert rst on the 4th SHIFT cycle -> next cycle ready=1, diff=0, no done pulse.
//     A new start then completes correctly.
//  6. WIDTH=4: exhaustive 16x16 sweep -> diff==(a-b)&4'hF and borrow==(a<b)
//     for all 256 pairs.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor -- bit-serial unsigned subtractor, LSB first.
//
// Computes a - b as a + ~b + 1 using one full_adder cell and a registered
// carry that starts at 1. One result bit is produced per clock.
//
// Optional feature macro: SERIAL_SUB_OVERFLOW_EN (adds the signed overflow port).
//
// Ports:
//   clk       in   1      clock, all state on posedge
//   rst       in   1      synchronous active-high reset
//   start     in   1      request, sampled only while ready=1
//   a, b      in   WIDTH  minuend / subtrahend, captured on accepted start
//   ready     out  1      idle, start will be accepted
//   done      out  1      one-cycle pulse, diff/borrow valid from this cycle
//   diff      out  WIDTH  a - b mod 2^WIDTH
//   borrow    out  1      a < b (unsigned)
//   overflow  out  1      signed overflow (SERIAL_SUB_OVERFLOW_EN only)

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, diff_q, diff_d;
  logic [WIDTH-2:0] res_q, res_d;   // partial result, MSB-filled
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic             ready_q, ready_d, done_q, done_d, borrow_q, borrow_d;
  logic             fa_s, fa_cout;
  logic [WIDTH-1:0] res_full;       // result after inserting this cycle's bit
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  full_adder u_fa (
    .a    (sa_q[0]),
    .b    (~sb_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign res_full = {fa_s, res_q};

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    count_d  = count_q;
    carry_d  = carry_q;
    ready_d  = ready_q;
    done_d   = done_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        done_d  = 1'b0;
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          carry_d = 1'b1;
          count_d = '0;
          ready_d = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        carry_d = fa_cout;
        res_d   = res_full[WIDTH-1:1];
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          diff_d   = res_full;
          borrow_d = ~fa_cout;
          done_d   = 1'b1;
          state_d  = DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
          // On the last step sa_q[0]/sb_q[0] are the captured operand MSBs
          // and fa_s is the result MSB.
          ovf_d    = (sa_q[0] != sb_q[0]) && (fa_s != sa_q[0]);
`endif
        end
      end
      DONE: begin
        done_d  = 1'b0;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        done_d  = 1'b0;
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      count_q  <= '0;
      carry_q  <= 1'b1;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      count_q  <= count_d;
      carry_q  <= carry_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 instance for functional,
// handshake and reset cases, WIDTH=4 instance for an exhaustive sweep.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       ready, done, borrow;
  logic [7:0] diff;
  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       ready4, done4, borrow4;
  logic [3:0] diff4;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic       ovf, ovf4;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .ready(ready), .done(done), .diff(diff), .borrow(borrow)
`ifdef SERIAL_SUB_OVERFLOW_EN
    , .overflow(ovf)
`endif
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .ready(ready4), .done(done4), .diff(diff4), .borrow(borrow4)
`ifdef SERIAL_SUB_OVERFLOW_EN
    , .overflow(ovf4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue one op from idle; lat = edges after acceptance until done seen (-1 on timeout).
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, output int lat);
    lat = -1;
    chk("ready_before_start", ready, 1);
    a = ta; b = tb_; start = 1'b1;
    tick();
    start = 1'b0; a = 8'($urandom); b = 8'($urandom);
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (done) begin lat = n; break; end
    end
  endtask

  task automatic op_check(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                          input logic [7:0] ed, input logic eb);
    int lat;
    do_op(ta, tb_, lat);
    chk({tag, "_latency"}, lat, 8);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_borrow"}, borrow, eb);
  endtask

  initial begin
    int lat, cnt, first, second;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;
    tick();

    // basic op and post-done handshake
    op_check("5m3", 8'd5, 8'd3, 8'd2, 1'b0);
    tick();
    chk("5m3_done_clear", done, 0);
    chk("5m3_ready_back", ready, 1);

    op_check("3m5", 8'd3, 8'd5, 8'hFE, 1'b1);
    tick();
    op_check("eq", 8'hA5, 8'hA5, 8'h00, 1'b0);
    tick();
    op_check("0m1", 8'd0, 8'd1, 8'hFF, 1'b1);
    tick();

    op_check("80m1", 8'h80, 8'h01, 8'h7F, 1'b0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("80m1_ovf", ovf, 1);
`endif
    tick();
    op_check("7Fm FF", 8'h7F, 8'hFF, 8'h80, 1'b1);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("7FmFF_ovf", ovf, 1);
`endif
    tick();
    op_check("10m4", 8'd10, 8'd4, 8'd6, 1'b0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("10m4_ovf", ovf, 0);
`endif
    tick();

    // start pulsed during SHIFT must be ignored
    a = 8'd5; b = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_ready", ready, 0);
    cnt = 0; first = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 2) begin start = 1'b1; a = 8'd0; b = 8'd0; end
      if (n == 3) start = 1'b0;
      if (done) begin cnt++; if (first < 0) first = n; end
    end
    chk("ignored_done_count", cnt, 1);
    chk("ignored_done_at", first, 8);
    chk("ignored_diff", diff, 8'd2);

    // held start: one op every WIDTH+2 cycles
    a = 8'd9; b = 8'd2; start = 1'b1;
    cnt = 0; first = -1; second = -1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (done) begin
        cnt++;
        if (first < 0) first = n; else if (second < 0) second = n;
      end
    end
    start = 1'b0;
    chk("held_interval", second - first, 10);
    chk("held_diff", diff, 8'd7);
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      if (ready) begin lat = n; break; end
      tick();
    end
    chk("held_drain", (lat >= 0), 1);

    // reset during the 4th SHIFT cycle aborts the op
    a = 8'd100; b = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("abort_ready", ready, 1);
    chk("abort_diff", diff, 0);
    chk("abort_borrow", borrow, 0);
    chk("abort_done", done, 0);
    rst = 1'b0;
    cnt = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (done) cnt++;
    end
    chk("abort_no_done", cnt, 0);
    op_check("after_abort", 8'd20, 8'd7, 8'd13, 1'b0);
    tick();

    // WIDTH=4 exhaustive sweep
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        logic [3:0] ed;
        ed = 4'(i - j);
        a4 = 4'(i); b4 = 4'(j); start4 = 1'b1;
        tick();
        start4 = 1'b0;
        lat = -1;
        for (int n = 1; n <= 12; n++) begin
          tick();
          if (done4) begin lat = n; break; end
        end
        if (lat != 4) chk("w4_latency", lat, 4);
        chk($sformatf("w4_diff_%0d_%0d", i, j), diff4, ed);
        chk($sformatf("w4_borrow_%0d_%0d", i, j), borrow4, (i < j));
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
